pattern_editor: RTL

PATTERN_EDITOR -- requirements
Module: pattern_editor

---
 rtl/pattern_editor.sv | 112 +++++++++++
 1 files changed

// File: rtl/pattern_editor.sv
// Step-sequencer pattern editor: five debounced buttons move a cursor and edit 4-bit pitches.
// Latency: raw button edge -> press event 2+DEBOUNCE_CYCLES+1 cycles; event -> beats/cursor next edge.
// Backpressure: none; button events are applied unconditionally the cycle they occur.
module pattern_editor #(
    parameter int NUM_BEATS       = 16,
    parameter int DEBOUNCE_CYCLES = 120_000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         btn_next,
    input  logic                         btn_prev,
    input  logic                         btn_up,
    input  logic                         btn_down,
    input  logic                         btn_clear,
    output logic [NUM_BEATS*4-1:0]       beats,
    output logic [$clog2(NUM_BEATS)-1:0] cursor,
    output logic [3:0]                   cursor_pitch,
    output logic                         edit_pulse
);

    localparam int CUR_W = $clog2(NUM_BEATS);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int NB    = 5;

    // Button index map: 0 next, 1 prev, 2 up, 3 down, 4 clear
    localparam int B_NEXT  = 0;
    localparam int B_PREV  = 1;
    localparam int B_UP    = 2;
    localparam int B_DOWN  = 3;
    localparam int B_CLEAR = 4;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    sync_a;
    logic [NB-1:0]    sync_b;
    logic [NB-1:0]    stable;
    logic [NB-1:0]    stable_q;
    logic [NB-1:0]    press;
    logic [CNT_W-1:0] cnt [NB];

    logic [NUM_BEATS*4-1:0] beats_d;
    logic [CUR_W-1:0]       cursor_d;
    logic [3:0]             pitch;
    logic                   edit;

    assign raw = {btn_clear, btn_down, btn_up, btn_prev, btn_next};

    // Synchronize, debounce and edge-detect every button; a press is the registered 0->1 of the stable level
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a   <= '0;
            sync_b   <= '0;
            stable   <= '0;
            stable_q <= '0;
            press    <= '0;
            for (int i = 0; i < NB; i++) cnt[i] <= '0;
        end else begin
            sync_a   <= raw;
            sync_b   <= sync_a;
            stable_q <= stable;
            press    <= stable & ~stable_q;
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign pitch        = beats[{cursor, 2'b00} +: 4];
    assign cursor_pitch = pitch;

    // Apply this cycle's events: pitch edit lands on the current step before the cursor moves
    always_comb begin
        beats_d  = beats;
        cursor_d = cursor;
        edit     = 1'b0;
        if (press[B_CLEAR]) begin
            beats_d = '0;
            edit    = 1'b1;
        end else if (press[B_UP] && !press[B_DOWN]) begin
            beats_d[{cursor, 2'b00} +: 4] = pitch + 4'd1;
            edit                          = 1'b1;
        end else if (press[B_DOWN] && !press[B_UP]) begin
            beats_d[{cursor, 2'b00} +: 4] = pitch - 4'd1;
            edit                          = 1'b1;
        end
        if (press[B_NEXT] && !press[B_PREV]) begin
            cursor_d = cursor + CUR_W'(1);
        end else if (press[B_PREV] && !press[B_NEXT]) begin
            cursor_d = cursor - CUR_W'(1);
        end
    end

    // Pattern, cursor and edit strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            beats      <= '0;
            cursor     <= '0;
            edit_pulse <= 1'b0;
        end else begin
            beats      <= beats_d;
            cursor     <= cursor_d;
            edit_pulse <= edit;
        end
    end

endmodule
